// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: majority-vote bit decisions, parity/frame/break
// detection and a first-word-fall-through receive FIFO.
module uart_rx_ovs #(
   parameter int U_DLY   = 1,
   parameter int OVS     = 16,
   parameter int FIFO_AW = 3
) (
   input  logic               clk_sys,
   input  logic               rst,
   input  logic               baud_en,
   input  logic [3:0]         data_width,
   input  logic [2:0]         parity_mode,
   input  logic               stop_bits,
   input  logic               parity_filter,
   input  logic               uart_rx,
   output logic [8:0]         rx_data,
   output logic [2:0]         rx_flags,
   output logic               rx_valid,
   input  logic               rx_ready,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               overflow,
   output logic               rx_busy
);

   localparam int TW    = $clog2(OVS);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [TW-1:0] T_S0   = TW'(OVS/2 - 1);
   localparam logic [TW-1:0] T_S1   = TW'(OVS/2);
   localparam logic [TW-1:0] T_DEC  = TW'(OVS/2 + 1);
   localparam logic [TW-1:0] T_LAST = TW'(OVS - 1);
   localparam logic [FIFO_AW:0] L_FULL = (FIFO_AW+1)'(DEPTH);

   if ((OVS < 8) || (OVS > 32) || ((OVS % 2) != 0) || (U_DLY < 0)) begin : g_bad_param
      $error("uart_rx_ovs: illegal parameter value");
   end

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

   // line synchronizer; resets high so reset release never looks like a start edge
   logic r_sync1, r_sync2, r_sync3;
   logic w_start_edge;

   state_t         r_state, w_state_n;
   logic [TW-1:0]  r_tick, w_tick_n;
   logic [3:0]     r_bitcnt, w_bitcnt_n;
   logic [8:0]     r_data, w_data_n;
   logic           r_s0, r_s1;
   logic           r_perr, w_perr_n;
   logic           r_ferr, w_ferr_n;
   logic           r_brk, w_brk_n;
   logic           r_zero, w_zero_n;
   logic           w_cfg_ld;
   logic [3:0]     r_width;
   logic [2:0]     r_pmode;
   logic           r_stop2, r_filter;
   logic           r_push, w_push_n;
   logic [11:0]    r_push_word, w_push_word_n;

   logic           w_run, w_decide, w_bound, w_bit, w_par_exp, w_last_stop;
   logic [3:0]     w_width_norm;
   logic [2:0]     w_pmode_norm;

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_sync3 <= 1'b1;
      end else begin
         r_sync1 <= uart_rx;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign w_start_edge = r_sync3 & ~r_sync2;

   assign w_width_norm = ((data_width >= 4'd5) && (data_width <= 4'd9)) ? data_width : 4'd8;
   assign w_pmode_norm = (parity_mode > 3'd4) ? 3'd0 : parity_mode;

   assign w_run    = (r_state != IDLE) && (r_state != BRK_WAIT);
   assign w_decide = baud_en && (r_tick == T_DEC);
   assign w_bound  = baud_en && (r_tick == T_LAST);
   assign w_bit    = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);
   assign w_last_stop = (r_bitcnt == 4'd1) || !r_stop2;

   always_comb begin
      case (r_pmode)
         3'd1:    w_par_exp = ~^r_data;
         3'd2:    w_par_exp = ^r_data;
         3'd3:    w_par_exp = 1'b1;
         default: w_par_exp = 1'b0;
      endcase
   end

   always_comb begin
      w_state_n     = r_state;
      w_tick_n      = r_tick;
      w_bitcnt_n    = r_bitcnt;
      w_data_n      = r_data;
      w_perr_n      = r_perr;
      w_ferr_n      = r_ferr;
      w_brk_n       = r_brk;
      w_zero_n      = r_zero;
      w_cfg_ld      = 1'b0;
      w_push_n      = 1'b0;
      w_push_word_n = r_push_word;
      if (w_run && baud_en)
         w_tick_n = (r_tick == T_LAST) ? '0 : r_tick + TW'(1);
      case (r_state)
         IDLE: begin
            if (w_start_edge) begin
               w_tick_n   = '0;
               w_bitcnt_n = '0;
               w_data_n   = '0;
               w_perr_n   = 1'b0;
               w_ferr_n   = 1'b0;
               w_brk_n    = 1'b0;
               w_zero_n   = 1'b1;
               w_cfg_ld   = 1'b1;
               w_state_n  = START;
            end
         end
         START: begin
            if (w_decide && w_bit)
               w_state_n = IDLE;
            else if (w_bound)
               w_state_n = DATA;
         end
         DATA: begin
            if (w_decide) begin
               w_data_n = r_data | ({8'd0, w_bit} << r_bitcnt);
               w_zero_n = r_zero & ~w_bit;
            end else if (w_bound) begin
               if (r_bitcnt == (r_width - 4'd1)) begin
                  w_bitcnt_n = '0;
                  w_state_n  = (r_pmode != 3'd0) ? PARITY : STOP;
               end else begin
                  w_bitcnt_n = r_bitcnt + 4'd1;
               end
            end
         end
         PARITY: begin
            if (w_decide) begin
               w_perr_n = (w_bit != w_par_exp);
               w_zero_n = r_zero & ~w_bit;
            end else if (w_bound) begin
               w_state_n = STOP;
            end
         end
         STOP: begin
            if (w_decide) begin
               w_ferr_n = r_ferr | ~w_bit;
               if (r_bitcnt == 4'd0)
                  w_brk_n = r_zero & ~w_bit;
               // the word leaves at mid-bit so a back-to-back start edge is not missed
               if (w_last_stop) begin
                  w_push_n      = ~(r_perr & r_filter);
                  w_push_word_n = {w_brk_n, r_perr, w_ferr_n | w_brk_n, r_data};
                  w_state_n     = w_brk_n ? BRK_WAIT : IDLE;
               end
            end else if (w_bound) begin
               w_bitcnt_n = 4'd1;
            end
         end
         BRK_WAIT: begin
            if (r_sync2)
               w_state_n = IDLE;
         end
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_tick      <= '0;
         r_bitcnt    <= '0;
         r_data      <= '0;
         r_s0        <= 1'b1;
         r_s1        <= 1'b1;
         r_perr      <= 1'b0;
         r_ferr      <= 1'b0;
         r_brk       <= 1'b0;
         r_zero      <= 1'b0;
         r_width     <= 4'd8;
         r_pmode     <= 3'd0;
         r_stop2     <= 1'b0;
         r_filter    <= 1'b0;
         r_push      <= 1'b0;
         r_push_word <= '0;
      end else begin
         r_state     <= w_state_n;
         r_tick      <= w_tick_n;
         r_bitcnt    <= w_bitcnt_n;
         r_data      <= w_data_n;
         r_perr      <= w_perr_n;
         r_ferr      <= w_ferr_n;
         r_brk       <= w_brk_n;
         r_zero      <= w_zero_n;
         r_push      <= w_push_n;
         r_push_word <= w_push_word_n;
         if (baud_en && (r_tick == T_S0))
            r_s0 <= r_sync2;
         if (baud_en && (r_tick == T_S1))
            r_s1 <= r_sync2;
         if (w_cfg_ld) begin
            r_width  <= w_width_norm;
            r_pmode  <= w_pmode_norm;
            r_stop2  <= stop_bits;
            r_filter <= parity_filter;
         end
      end
   end

   // receive FIFO, first-word-fall-through
   logic [11:0]        r_mem [DEPTH];
   logic [FIFO_AW-1:0] r_wptr, r_rptr;
   logic [FIFO_AW:0]   r_level;
   logic               r_overflow;
   logic               w_pop, w_full, w_wr;
   logic [11:0]        w_head;

   assign w_pop  = rx_valid & rx_ready;
   assign w_full = (r_level == L_FULL);
   assign w_wr   = r_push & (~w_full | w_pop);
   assign w_head = r_mem[r_rptr];

   always_ff @(posedge clk_sys) begin
      if (w_wr)
         r_mem[r_wptr] <= r_push_word;
   end

   always_ff @(posedge clk_sys or posedge rst) begin
      if (rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr)
            r_wptr <= r_wptr + FIFO_AW'(1);
         if (w_pop)
            r_rptr <= r_rptr + FIFO_AW'(1);
         case ({w_wr, w_pop})
            2'b10:   r_level <= r_level + (FIFO_AW+1)'(1);
            2'b01:   r_level <= r_level - (FIFO_AW+1)'(1);
            default: r_level <= r_level;
         endcase
         r_overflow <= r_push & w_full & ~w_pop;
      end
   end

   assign rx_valid   = (r_level != '0);
   assign rx_data    = rx_valid ? w_head[8:0]  : 9'd0;
   assign rx_flags   = rx_valid ? w_head[11:9] : 3'd0;
   assign fifo_level = r_level;
   assign overflow   = r_overflow;
   assign rx_busy    = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Randomized scoreboard bench for uart_rx_ovs: frames are built from the line
// protocol rules, expected words queued, and a monitor pops on every handshake.
module tb_uart_rx_ovs;
   localparam int OVS     = 16;
   localparam int FIFO_AW = 2;
   localparam int BDIV    = 3;
   localparam int BIT     = OVS * BDIV;

   logic             clk_sys = 1'b0;
   logic             rst = 1'b1;
   logic             baud_en = 1'b0;
   logic [3:0]       data_width = 4'd8;
   logic [2:0]       parity_mode = 3'd0;
   logic             stop_bits = 1'b0;
   logic             parity_filter = 1'b0;
   logic             uart_rx = 1'b1;
   logic [8:0]       rx_data;
   logic [2:0]       rx_flags;
   logic             rx_valid;
   logic             rx_ready = 1'b0;
   logic [FIFO_AW:0] fifo_level;
   logic             overflow;
   logic             rx_busy;

   always #5 clk_sys = ~clk_sys;

   uart_rx_ovs #(.U_DLY(1), .OVS(OVS), .FIFO_AW(FIFO_AW)) dut (
      .clk_sys(clk_sys), .rst(rst), .baud_en(baud_en),
      .data_width(data_width), .parity_mode(parity_mode),
      .stop_bits(stop_bits), .parity_filter(parity_filter),
      .uart_rx(uart_rx), .rx_data(rx_data), .rx_flags(rx_flags),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .fifo_level(fifo_level),
      .overflow(overflow), .rx_busy(rx_busy)
   );

   logic [11:0] exp_q[$];
   int total = 0, bad = 0, vld_cycles = 0, ovf_cnt = 0;
   bit rnd_rdy = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic monitor();
      logic [11:0] e;
      forever begin
         @(negedge clk_sys);
         if (rx_valid) vld_cycles++;
         if (overflow) ovf_cnt++;
         if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_word: got %0h want none", {rx_flags, rx_data});
            end else begin
               e = exp_q.pop_front();
               chk("word", {20'd0, rx_flags, rx_data}, {20'd0, e});
            end
         end
      end
   endtask

   task automatic baud_gen();
      int c = 0;
      forever begin
         @(posedge clk_sys);
         #1;
         baud_en = (c == 0);
         c = (c + 1) % BDIV;
      end
   endtask

   task automatic ready_drv();
      forever begin
         @(posedge clk_sys);
         #1;
         if (rnd_rdy) rx_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic drive_bit(input logic v);
      uart_rx = v;
      tick(BIT);
   endtask

   // Builds one frame from the protocol rules and queues the word it should yield.
   task automatic send_frame(input logic [8:0] d, input logic [3:0] dw, input logic [2:0] pm,
                             input logic s2, input logic pf, input bit flip, input bit bad_stop,
                             input bit drop, input bit scramble);
      int w;
      bit pen;
      logic pexp, pbit, perr, ferr, brk;
      logic [8:0] mask, dm;
      w    = (dw >= 4'd5 && dw <= 4'd9) ? int'(dw) : 8;
      mask = 9'h1FF >> (9 - w);
      dm   = d & mask;
      pen  = (pm >= 3'd1 && pm <= 3'd4);
      case (pm)
         3'd1:    pexp = ~(^dm);
         3'd2:    pexp = ^dm;
         3'd3:    pexp = 1'b1;
         default: pexp = 1'b0;
      endcase
      pbit = pexp ^ flip;
      perr = pen && flip;
      ferr = bad_stop;
      brk  = (dm == 9'd0) && (!pen || !pbit) && bad_stop;
      if (!drop && !(perr && pf))
         exp_q.push_back({brk, perr, ferr | brk, dm});
      data_width = dw; parity_mode = pm; stop_bits = s2; parity_filter = pf;
      drive_bit(1'b0);
      if (scramble) begin
         data_width = 4'($urandom); parity_mode = 3'($urandom);
         stop_bits = 1'($urandom); parity_filter = 1'($urandom);
      end
      for (int i = 0; i < w; i++) drive_bit(dm[i]);
      if (pen) drive_bit(pbit);
      drive_bit(!bad_stop);
      if (s2) drive_bit(1'b1);
      uart_rx = 1'b1;
      tick($urandom_range(8, BIT));
   endtask

   task automatic drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 3000) begin
         tick(1);
         k++;
      end
      chk("drain_empty", exp_q.size(), 0);
      tick(4);
   endtask

   initial begin
      logic [8:0] d;
      int o0;
      fork
         monitor();
         baud_gen();
         ready_drv();
      join_none

      tick(5);
      chk("rst_rx_data", rx_data, 0);
      chk("rst_rx_flags", rx_flags, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_busy", rx_busy, 0);
      rst = 1'b0;
      tick(5);
      chk("idle_busy", rx_busy, 0);

      // 8N1 0xA5 with continuous ready: one word, valid for a single cycle
      rx_ready = 1'b1;
      vld_cycles = 0;
      send_frame(9'h0A5, 4'd8, 3'd0, 1'b0, 1'b0, 0, 0, 0, 0);
      tick(10);
      chk("a5_valid_cycles", vld_cycles, 1);
      drain();

      // 9-bit even parity: good, bad unfiltered, bad filtered
      send_frame(9'h1FF, 4'd9, 3'd2, 1'b0, 1'b0, 0, 0, 0, 0);
      send_frame(9'h1FF, 4'd9, 3'd2, 1'b0, 1'b0, 1, 0, 0, 0);
      send_frame(9'h1FF, 4'd9, 3'd2, 1'b0, 1'b1, 1, 0, 0, 0);
      drain();
      chk("parity_level", fifo_level, 0);

      // short low glitch is a false start
      uart_rx = 1'b0;
      tick(4 * BDIV);
      uart_rx = 1'b1;
      tick(2);
      chk("glitch_busy_hi", rx_busy, 1);
      tick(BIT);
      chk("glitch_busy_lo", rx_busy, 0);
      chk("glitch_level", fifo_level, 0);

      // fill a 4-deep FIFO with 5 frames
      rx_ready = 1'b0;
      o0 = ovf_cnt;
      for (int i = 1; i <= 5; i++)
         send_frame(9'(i), 4'd8, 3'd0, 1'b0, 1'b0, 0, 0, (i == 5), 0);
      tick(5);
      chk("ovf_level", fifo_level, 4);
      chk("ovf_pulses", ovf_cnt - o0, 1);
      chk("ovf_valid", rx_valid, 1);
      rx_ready = 1'b1;
      drain();
      chk("ovf_drained", fifo_level, 0);

      // break: line low for two 8N2 frame times
      data_width = 4'd8; parity_mode = 3'd0; stop_bits = 1'b1; parity_filter = 1'b0;
      exp_q.push_back({3'b101, 9'h000});
      uart_rx = 1'b0;
      tick(22 * BIT);
      chk("brk_wait_busy", rx_busy, 1);
      uart_rx = 1'b1;
      tick(8);
      chk("brk_idle_busy", rx_busy, 0);
      tick(BIT);
      send_frame(9'h033, 4'd8, 3'd0, 1'b1, 1'b0, 0, 0, 0, 0);
      drain();

      // reset in the middle of data bit 3 with one word already buffered
      rx_ready = 1'b0;
      send_frame(9'h03C, 4'd8, 3'd0, 1'b0, 1'b0, 0, 0, 0, 0);
      chk("pre_rst_level", fifo_level, 1);
      d = 9'h05A;
      data_width = 4'd8; parity_mode = 3'd0; stop_bits = 1'b0;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(d[i]);
      uart_rx = d[3];
      tick(BIT / 2);
      rst = 1'b1;
      uart_rx = 1'b1;
      tick(2);
      chk("mid_rst_data", rx_data, 0);
      chk("mid_rst_flags", rx_flags, 0);
      chk("mid_rst_valid", rx_valid, 0);
      chk("mid_rst_level", fifo_level, 0);
      chk("mid_rst_overflow", overflow, 0);
      chk("mid_rst_busy", rx_busy, 0);
      exp_q.delete();
      rst = 1'b0;
      tick(BIT);
      chk("post_rst_level", fifo_level, 0);
      rx_ready = 1'b1;
      send_frame(d, 4'd8, 3'd0, 1'b0, 1'b0, 0, 0, 0, 0);
      drain();

      // randomized frames, mid-frame config scrambling, random backpressure
      rnd_rdy = 1'b1;
      for (int n = 0; n < 30; n++) begin
         d = 9'($urandom);
         if ($urandom_range(0, 7) == 0) d = 9'd0;
         send_frame(d, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                    1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 5) == 0), 0, 1);
      end
      rnd_rdy = 1'b0;
      rx_ready = 1'b1;
      drain();
      chk("final_level", fifo_level, 0);
      chk("total_overflows", ovf_cnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
